// File: rtl/dram_cmd_responder.sv
// dram_cmd_responder: cycle-level DRAM bank model that checks command timing, stores data and returns reads after CL.
module dram_cmd_responder #(
    parameter int NUM_BANKS = 4,
    parameter int ROW_W     = 4,
    parameter int COL_W     = 3,
    parameter int DATA_W    = 64,
    parameter int CL        = 5,
    parameter int TRCD      = 4,
    parameter int TRP       = 4,
    parameter int TRAS      = 10
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cmd_valid,
    input  logic [2:0]                                  cmd_op,
    input  logic [$clog2(NUM_BANKS)-1:0]                cmd_bank,
    input  logic [(ROW_W > COL_W ? ROW_W : COL_W)-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]                           wr_data,
    output logic                                        rd_valid,
    output logic [DATA_W-1:0]                           rd_data,
    output logic                                        err_valid,
    output logic [2:0]                                  err_code,
    output logic [NUM_BANKS-1:0]                        bank_open
);
    localparam int BW    = $clog2(NUM_BANKS);
    localparam int SAT0  = TRAS > TRP ? TRAS : TRP;
    localparam int SAT   = SAT0 > TRCD ? SAT0 : TRCD;
    localparam int CW    = $clog2(SAT + 1);
    localparam int MW    = BW + ROW_W + COL_W;
    localparam logic [CW-1:0] SAT_C  = CW'(SAT);
    localparam logic [CW-1:0] TRCD_C = CW'(TRCD);
    localparam logic [CW-1:0] TRP_C  = CW'(TRP);
    localparam logic [CW-1:0] TRAS_C = CW'(TRAS);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [2:0] OP_ACT = 3'd1, OP_PRE = 3'd2, OP_RD = 3'd3, OP_WR = 3'd4, OP_REF = 3'd5;

    logic [CW-1:0]     act_cnt  [NUM_BANKS];
    logic [CW-1:0]     pre_cnt  [NUM_BANKS];
    logic [ROW_W-1:0]  open_row [NUM_BANKS];
    logic [DATA_W-1:0] mem      [1 << MW];
    logic [DATA_W-1:0] pipe_d   [CL];
    logic [CL-1:0]     pipe_v;
    logic [2:0]        code;
    logic              b_open, ok, act_ok, pre_ok, rd_ok, wr_ok;
    logic [CW-1:0]     a_cnt, p_cnt;
    logic [MW-1:0]     mem_addr;

    always_comb begin
        b_open   = bank_open[cmd_bank];
        a_cnt    = act_cnt[cmd_bank];
        p_cnt    = pre_cnt[cmd_bank];
        code     = !cmd_valid ? 3'd0 :
                   cmd_op == OP_ACT ? (b_open ? 3'd1 : p_cnt < TRP_C ? 3'd2 : 3'd0) :
                   cmd_op == OP_PRE ? (b_open && a_cnt < TRAS_C ? 3'd5 : 3'd0) :
                   (cmd_op == OP_RD || cmd_op == OP_WR) ? (!b_open ? 3'd3 : a_cnt < TRCD_C ? 3'd4 : 3'd0) :
                   cmd_op == OP_REF ? (|bank_open ? 3'd6 : 3'd0) :
                   cmd_op >= 3'd6 ? 3'd7 : 3'd0;
        ok       = cmd_valid && !rst && code == 3'd0;
        act_ok   = ok && cmd_op == OP_ACT;
        pre_ok   = ok && cmd_op == OP_PRE && b_open;
        rd_ok    = ok && cmd_op == OP_RD;
        wr_ok    = ok && cmd_op == OP_WR;
        mem_addr = {cmd_bank, open_row[cmd_bank], cmd_addr[COL_W-1:0]};
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[mem_addr] <= wr_data;
    end

    // Counters load 1 on ACT/PRE so a command issued k cycles later sees k.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open <= '0;
            pipe_v    <= '0;
            err_valid <= 1'b0;
            err_code  <= 3'd0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                act_cnt[i] <= SAT_C;
                pre_cnt[i] <= SAT_C;
            end
            for (int k = 0; k < CL; k++) pipe_d[k] <= '0;
        end else begin
            err_valid <= code != 3'd0;
            err_code  <= code;
            for (int i = 0; i < NUM_BANKS; i++) begin
                act_cnt[i] <= act_ok && cmd_bank == BW'(i) ? ONE :
                              act_cnt[i] == SAT_C ? act_cnt[i] : act_cnt[i] + ONE;
                pre_cnt[i] <= pre_ok && cmd_bank == BW'(i) ? ONE :
                              pre_cnt[i] == SAT_C ? pre_cnt[i] : pre_cnt[i] + ONE;
                if (act_ok && cmd_bank == BW'(i)) begin
                    bank_open[i] <= 1'b1;
                    open_row[i]  <= cmd_addr[ROW_W-1:0];
                end
                if (pre_ok && cmd_bank == BW'(i)) bank_open[i] <= 1'b0;
            end
            pipe_v[0] <= rd_ok;
            pipe_d[0] <= rd_ok ? mem[mem_addr] : '0;
            for (int k = 1; k < CL; k++) begin
                pipe_v[k] <= pipe_v[k-1];
                pipe_d[k] <= pipe_d[k-1];
            end
        end
    end

    assign rd_valid = pipe_v[CL-1];
    assign rd_data  = pipe_d[CL-1];
endmodule

// File: tb/tb_dram_cmd_responder.sv
// tb_dram_cmd_responder: directed and random commands checked against a timestamp-based bank model.
module tb_dram_cmd_responder;
    localparam int CL = 5, TRCD = 4, TRP = 4, TRAS = 10;

    logic        clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0;
    logic [2:0]  cmd_op = '0;
    logic [1:0]  cmd_bank = '0;
    logic [3:0]  cmd_addr = '0;
    logic [63:0] wr_data = '0;
    logic        rd_valid, err_valid;
    logic [63:0] rd_data;
    logic [2:0]  err_code;
    logic [3:0]  bank_open;

    dram_cmd_responder dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
        .cmd_addr(cmd_addr), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .err_valid(err_valid), .err_code(err_code), .bank_open(bank_open)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0, exp_code;
    bit m_open [4];
    int m_row [4], last_act [4], last_pre [4];
    logic [63:0] mem_m [int];
    logic [63:0] rq [int];
    bit rk [int];
    logic [63:0] got [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            m_open[b] = 0;
            last_act[b] = -1000;
            last_pre[b] = -1000;
        end
        rq.delete();
        rk.delete();
    endtask

    function automatic int model_code(input int op, input int b);
        bit any = 0;
        for (int i = 0; i < 4; i++) any |= m_open[i];
        case (op)
            1: return m_open[b] ? 1 : (cyc - last_pre[b] < TRP) ? 2 : 0;
            2: return (m_open[b] && cyc - last_act[b] < TRAS) ? 5 : 0;
            3, 4: return !m_open[b] ? 3 : (cyc - last_act[b] < TRCD) ? 4 : 0;
            5: return any ? 6 : 0;
            6, 7: return 7;
            default: return 0;
        endcase
    endfunction

    function automatic int maddr(input int b, input int col);
        return (b << 7) | (m_row[b] << 3) | (col & 7);
    endfunction

    task automatic step(input bit v, input int op, input int b, input int a, input logic [63:0] d);
        logic [3:0] exp_open;
        int ad;
        cmd_valid = v; cmd_op = 3'(op); cmd_bank = 2'(b); cmd_addr = 4'(a); wr_data = d;
        exp_code = v ? model_code(op, b) : 0;
        @(posedge clk); #1;
        if (v && exp_code == 0) begin
            ad = maddr(b, a);
            case (op)
                1: begin m_open[b] = 1; m_row[b] = a & 15; last_act[b] = cyc; end
                2: if (m_open[b]) begin m_open[b] = 0; last_pre[b] = cyc; end
                3: begin rk[cyc + CL] = mem_m.exists(ad); rq[cyc + CL] = mem_m.exists(ad) ? mem_m[ad] : 'x; end
                4: mem_m[ad] = d;
                default: ;
            endcase
        end
        cyc++;
        for (int i = 0; i < 4; i++) exp_open[i] = m_open[i];
        chk("bank_open", bank_open, exp_open);
        chk("err_valid", err_valid, exp_code != 0);
        chk("err_code", err_code, exp_code);
        chk("rd_valid", rd_valid, rq.exists(cyc));
        if (rd_valid) got.push_back(rd_data);
        if (!rq.exists(cyc)) chk("rd_data_idle", rd_data, 0);
        else begin
            if (rk[cyc]) chk("rd_data", rd_data, rq[cyc]);
            rq.delete(cyc);
            rk.delete(cyc);
        end
    endtask

    task automatic nop(input int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        model_reset();
        repeat (n) begin
            cmd_valid = 1; cmd_op = 3'($urandom_range(1, 4)); cmd_bank = 2'($urandom);
            cmd_addr = 4'($urandom); wr_data = {$urandom, $urandom};
            @(posedge clk); #1;
            cyc++;
            chk("rst_bank_open", bank_open, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_rd_data", rd_data, 0);
            chk("rst_err_valid", err_valid, 0);
            chk("rst_err_code", err_code, 0);
        end
        rst = 0;
        cmd_valid = 0;
    endtask

    initial begin
        int r, x, op;
        model_reset();
        do_reset(2);
        // basic write then read-back with CL latency
        got.delete();
        step(1, 1, 0, 3, 0);
        nop(3);
        step(1, 4, 0, 2, 64'hA5A5);
        step(1, 3, 0, 2, 0);
        nop(6);
        chk("basic_rd_count", got.size(), 1);
        if (got.size() == 1) chk("basic_rd_data", got[0], 64'hA5A5);
        // RD before TRCD
        step(1, 1, 1, 0, 0);
        nop(1);
        step(1, 3, 1, 0, 0);
        chk("trcd_code", err_code, 4);
        // PRE before TRAS, legal PRE, ACT before TRP
        step(1, 1, 2, 5, 0);
        nop(2);
        step(1, 2, 2, 0, 0);
        chk("tras_code", err_code, 5);
        chk("tras_open", bank_open[2], 1);
        nop(6);
        step(1, 2, 2, 0, 0);
        chk("pre_closed", bank_open[2], 0);
        nop(1);
        step(1, 1, 2, 5, 0);
        chk("trp_code", err_code, 2);
        // back-to-back reads
        for (int i = 0; i < 4; i++) step(1, 4, 1, i, 64'(i + 1));
        got.delete();
        for (int i = 0; i < 4; i++) step(1, 3, 1, i, 0);
        nop(6);
        chk("burst_count", got.size(), 4);
        if (got.size() == 4) for (int i = 0; i < 4; i++) chk("burst_data", got[i], 64'(i + 1));
        // REF with bank open, illegal op, RD to closed bank
        step(1, 5, 0, 0, 0);
        chk("ref_code", err_code, 6);
        step(1, 7, 0, 0, 0);
        chk("illegal_code", err_code, 7);
        step(1, 3, 3, 0, 0);
        chk("closed_code", err_code, 3);
        // reset with a read in flight
        got.delete();
        step(1, 3, 0, 2, 0);
        nop(1);
        do_reset(2);
        nop(8);
        chk("flush_count", got.size(), 0);
        chk("flush_open", bank_open, 0);
        // randomized traffic
        repeat (800) begin
            r = $urandom_range(0, 99);
            if (r == 0) do_reset(1);
            else begin
                x = $urandom_range(0, 15);
                op = x < 4 ? 1 : x < 7 ? 2 : x < 11 ? 3 : x < 14 ? 4 : x == 14 ? 5 : $urandom_range(0, 7);
                step(r < 85, op, $urandom_range(0, 3), $urandom_range(0, 15), {$urandom, $urandom});
            end
        end
        nop(CL + 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
